uart_tx: RTL and testbench

// - Memory-mapped UART transmitter (8N1, LSB first) on the rysy_core data port.
// - Consumes the core's addr/wdata/we/be and returns registered rdata one cycle later,

---
 rtl/rysy_pkg.sv | 4 +
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo.sv | 57 +++++
 rtl/uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/rysy_pkg.sv
// rtl/rysy_pkg.sv - rysy_core shared data-port constants
package rysy_pkg;
    localparam int REG_LEN = 32;
endpackage

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART transmitter states, register offsets and STATUS bit positions
package uart_pkg;
    typedef logic [1:0] uart_state_t;

    localparam uart_state_t S_IDLE  = 2'd0;
    localparam uart_state_t S_START = 2'd1;
    localparam uart_state_t S_DATA  = 2'd2;
    localparam uart_state_t S_STOP  = 2'd3;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;
endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - register FIFO feeding the UART serialiser
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A simultaneous pop frees a slot, so a push on a full FIFO still lands.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO on the rysy_core data port
import rysy_pkg::*;
import uart_pkg::*;

module uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_LEN-1:0] addr,
    input  logic [REG_LEN-1:0] wdata,
    input  logic               we,
    input  logic [3:0]         be,
    output logic [REG_LEN-1:0] rdata,
    output logic               tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          hit;
    logic [1:0]    offset;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic [15:0]   baud_div;
    logic          overflow;
    logic          ovf_set;
    logic          ovf_clr;
    logic [31:0]   status_word;
    logic [31:0]   rd_next;

    uart_state_t   state;
    logic [7:0]    shift;
    logic [15:0]   div_q;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_cnt;
    logic          busy;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:16], be[3:2]};

    assign hit    = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset = addr[3:2];
    assign push   = we && hit && (offset == OFF_DATA) && be[0];
    assign ovf_clr = we && hit && (offset == OFF_STATUS) && be[0] && wdata[ST_OVF];
    assign busy   = (state != S_IDLE);

    // The serialiser takes a byte whenever it is idle or finishing a stop bit.
    assign pop = !fifo_empty &&
                 ((state == S_IDLE) || ((state == S_STOP) && (baud_cnt == 16'd0)));
    assign ovf_set = push && fifo_full && !pop;

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_div <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (we && hit && (offset == OFF_BAUD)) begin
                if (be[0]) baud_div[7:0]  <= wdata[7:0];
                if (be[1]) baud_div[15:8] <= wdata[15:8];
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        status_word                         = '0;
        status_word[ST_FULL]                = fifo_full;
        status_word[ST_EMPTY]               = fifo_empty;
        status_word[ST_BUSY]                = busy;
        status_word[ST_OVF]                 = overflow;
        status_word[ST_COUNT_LSB +: CW]     = fifo_count;
    end

    always_comb begin
        rd_next = '0;
        if (hit) begin
            case (offset)
                OFF_STATUS: rd_next = status_word;
                OFF_BAUD:   rd_next = {16'd0, baud_div};
                default:    rd_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= rd_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            div_q    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift    <= fifo_dout;
                        div_q    <= baud_div;
                        baud_cnt <= baud_div;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= div_q;
                        tx       <= shift[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= div_q;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud_cnt == 16'd0) begin
                        if (pop) begin
                            shift    <= fifo_dout;
                            div_q    <= baud_div;
                            baud_cnt <= baud_div;
                            bit_cnt  <= '0;
                            tx       <= 1'b0;
                            state    <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        tx;

    int n_checks = 0;
    int n_err    = 0;

    uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .be    (be),
        .rdata (rdata),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        addr  = a;
        wdata = d;
        be    = b;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
        be    = 4'h0;
        addr  = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        @(negedge clk);
        d    = rdata;
        addr = 32'h0;
    endtask

    // Samples tx once per cycle across a whole frame and decodes mid-bit.
    task automatic rx_frame(input logic [7:0] exp, input int div, input bit wait_start, input string tag);
        int         bad = 0;
        bit         ok  = 1'b1;
        logic [7:0] got = 8'h00;
        logic       expb;
        int         k;
        if (wait_start) begin
            ok = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                if (tx === 1'b0) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check({tag, "_start_seen"}, {31'd0, ok}, 32'd1);
        end
        if (ok) begin
            for (int c = 0; c < 10 * (div + 1); c++) begin
                k = c / (div + 1);
                if (k == 0)      expb = 1'b0;
                else if (k == 9) expb = 1'b1;
                else             expb = exp[k-1];
                if (tx !== expb) bad++;
                if (k >= 1 && k <= 8 && (c % (div + 1)) == div / 2) got[k-1] = tx;
                @(negedge clk);
            end
            check({tag, "_bad_cycles"}, bad, 0);
            check({tag, "_byte"}, {24'd0, got}, {24'd0, exp});
        end
    endtask

    task automatic count_low(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1) lows++;
            @(negedge clk);
        end
    endtask

    logic [31:0] d;
    int          lows;

    initial begin
        rst   = 1'b1;
        addr  = 32'h0;
        wdata = 32'h0;
        we    = 1'b0;
        be    = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_rdata", rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        bus_read(BASE + 32'h4, d);  check("reset_status", d, 32'h0000_0002);
        bus_read(BASE + 32'h8, d);  check("reset_baud", d, 32'h0000_0003);
        bus_read(BASE + 32'h0, d);  check("data_reads_zero", d, 32'h0);
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        bus_read(BASE + 32'hC, d);  check("reg_c_zero", d, 32'h0);

        bus_write(BASE + 32'h8, 32'hFFFF_AB07, 4'b0010);
        bus_read(BASE + 32'h8, d);  check("baud_be1", d, 32'h0000_AB03);
        bus_write(BASE + 32'h8, 32'h0000_0003, 4'b0011);
        bus_read(BASE + 32'h8, d);  check("baud_restore", d, 32'h0000_0003);

        bus_write(BASE, 32'h55, 4'h1);
        rx_frame(8'h55, 3, 1'b1, "single");
        bus_read(BASE + 32'h4, d);  check("single_idle", d, 32'h0000_0002);

        bus_write(BASE, 32'hA5, 4'h1);
        bus_write(BASE, 32'h3C, 4'h1);
        rx_frame(8'hA5, 3, 1'b1, "b2b_1");
        rx_frame(8'h3C, 3, 1'b0, "b2b_2");
        bus_read(BASE + 32'h4, d);  check("b2b_idle", d, 32'h0000_0002);

        fork
            begin
                rx_frame(8'h11, 3, 1'b1, "ovf_first");
                for (int i = 1; i <= 8; i++) begin
                    rx_frame(i[7:0], 3, 1'b0, $sformatf("ovf_q%0d", i));
                end
            end
            begin
                bus_write(BASE, 32'h11, 4'h1);
                repeat (3) @(negedge clk);
                for (int i = 1; i <= 9; i++) begin
                    bus_write(BASE, i, 4'h1);
                end
                bus_read(BASE + 32'h4, d);  check("ovf_status", d, 32'h0000_080D);
                bus_write(BASE + 32'h4, 32'h8, 4'h1);
                bus_read(BASE + 32'h4, d);  check("ovf_cleared", d, 32'h0000_0805);
            end
        join
        bus_read(BASE + 32'h4, d);  check("ovf_drained", d, 32'h0000_0002);

        fork
            rx_frame(8'hA5, 3, 1'b1, "baud_old");
            begin
                bus_write(BASE, 32'hA5, 4'h1);
                bus_write(BASE, 32'h3C, 4'h1);
                repeat (8) @(negedge clk);
                bus_write(BASE + 32'h8, 32'h0, 4'b0011);
            end
        join
        rx_frame(8'h3C, 0, 1'b0, "baud_new");
        bus_write(BASE + 32'h8, 32'h3, 4'b0011);

        bus_write(BASE + 32'h10, 32'h77, 4'hF);
        bus_read(BASE + 32'h10, d);  check("miss_rdata", d, 32'h0);
        bus_read(BASE + 32'h4, d);   check("miss_status", d, 32'h0000_0002);
        count_low(50, lows);         check("miss_no_tx", lows, 0);

        bus_write(BASE, 32'h00, 4'h1);
        bus_write(BASE, 32'h33, 4'h1);
        repeat (10) @(negedge clk);
        check("pre_rst_tx_low", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_tx_async", {31'd0, tx}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_read(BASE + 32'h4, d);   check("rst_status", d, 32'h0000_0002);
        count_low(60, lows);         check("rst_no_tx", lows, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
